// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between the CPU
// data path (port 0) and a debug/loader master (port 1), with fixed read latency.
module dmem_arbiter #(
    parameter int DW     = 32,
    parameter int AW     = 32,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
        $fatal(1, "dmem_arbiter: RD_LAT must be in 1..4");
    end

    typedef enum logic {IDLE, RD_WAIT} state_t;
    localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);

    state_t        state_q;
    logic [1:0]    cnt_q;
    logic          last_grant_q;
    logic          owner_q;
    logic          rd_ret_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          pick1;
    logic          any_gnt;
    logic          sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    always_comb begin
        // NOTE: every output of this block is assigned on every path, so no latch is inferred.
        pick1     = m1_req && (!m0_req || !last_grant_q);
        any_gnt   = reset && (state_q == IDLE) && (m0_req || m1_req);
        sel_we    = pick1 ? m1_we    : m0_we;
        sel_addr  = pick1 ? m1_addr  : m0_addr;
        sel_wdata = pick1 ? m1_wdata : m0_wdata;
    end

    assign m0_gnt    = any_gnt && !pick1;
    assign m1_gnt    = any_gnt && pick1;
    assign mem_en    = any_gnt;
    assign mem_we    = any_gnt && sel_we;
    assign mem_addr  = any_gnt ? sel_addr  : addr_q;
    assign mem_wdata = any_gnt ? sel_wdata : wdata_q;

    // Read data is steered straight from the memory in the return cycle, held otherwise.
    assign m0_rvalid = rd_ret_q && !owner_q;
    assign m1_rvalid = rd_ret_q && owner_q;
    assign m0_rdata  = m0_rvalid ? mem_rdata : rdata0_q;
    assign m1_rdata  = m1_rvalid ? mem_rdata : rdata1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            rd_ret_q     <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all state updates simultaneous at the edge.
            rd_ret_q <= 1'b0;
            if (any_gnt) begin
                last_grant_q <= pick1;
                addr_q       <= sel_addr;
                wdata_q      <= sel_wdata;
            end
            if (m0_rvalid) rdata0_q <= mem_rdata;
            if (m1_rvalid) rdata1_q <= mem_rdata;
            case (state_q)
                IDLE: begin
                    if (any_gnt && !sel_we) begin
                        owner_q <= pick1;
                        if (RD_LAT == 1) begin
                            rd_ret_q <= 1'b1;
                        end else begin
                            state_q <= RD_WAIT;
                            cnt_q   <= LAT_M1;
                        end
                    end
                end
                RD_WAIT: begin
                    if (cnt_q == 2'd1) begin
                        state_q  <= IDLE;
                        rd_ret_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 (CPU load/store path, source of MemWrite/DataAdr/WriteData) and port 1 (debug/loader master that preloads and inspects memory).
- Sits between the core's data-memory interface and the memory instance.
- Arbitration is round-robin with a req/gnt handshake.
- Read data returns after a fixed memory latency.

Parameters:
- DW, 32, data width of all data buses
- AW, 32, address width
- RD_LAT, 1, memory read latency in cycles (legal 1..4)

Ports:
- clk  in  1  clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- m0_req  in  1  port 0 access request
- m0_we  in  1  port 0 write enable (1 = write, 0 = read)
- m0_addr  in  AW  port 0 byte address
- m0_wdata  in  DW  port 0 write data
- m0_gnt  out  1  port 0 granted this cycle
- m0_rvalid  out  1  port 0 read data valid
- m0_rdata  out  DW  port 0 read data
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as port 0, for port 1
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid RD_LAT cycles after a read mem_en

Behaviour:
- Reset (reset=0, async) values:
  - gnt, rvalid, mem_en, mem_we = 0
  - mem_addr, mem_wdata, rdata = 0
  - state = IDLE
  - last_grant = 1, so port 0 wins the first tie
  - latency counter = 0
- Requester rules: hold req/we/addr/wdata stable until the cycle its gnt=1. Deassert req, or present a new request, the cycle after gnt.
- States:
  - IDLE: may grant.
  - RD_WAIT: read outstanding; no grants.
- Grant (IDLE only, combinational in the same cycle):
  - Only one req=1: that port wins.
  - Both req=1: the port != last_grant wins.
  - The winner's gnt=1 for exactly that cycle.
  - mem_en=1; mem_we/mem_addr/mem_wdata pass through from the winner that cycle.
  - last_grant updates at the clock edge.
  - With no grant: mem_en=0, mem_we=0, mem_addr/mem_wdata hold their last value.
- Write:
  - Completes in the grant cycle; state stays IDLE.
  - Back-to-back writes sustain 1 per cycle, alternating ports under contention.
- Read granted at cycle T:
  - Owner id is latched.
  - If RD_LAT>1: state=RD_WAIT for cycles T+1..T+RD_LAT-1, with a counter loaded with RD_LAT-1.
  - At cycle T+RD_LAT: owner's rvalid=1 for one cycle, owner's rdata=mem_rdata (combinational), state=IDLE. A new grant is permitted in that same cycle.
  - RD_LAT=1: no RD_WAIT; back-to-back reads at 1 per cycle.
- rdata of the non-owner port holds its last value; rvalid is never asserted on both ports in one cycle.
- Requests arriving in RD_WAIT are stalled (gnt=0) without loss while req is held.
- Reset mid-read: the outstanding read is dropped (no rvalid) and state returns to IDLE.
- Port 1 may access any address; there is no protection or address decode in this block.
- A reserved RD_LAT value outside 1..4 is a fatal elaboration error.

Test Plan:
- RD_LAT=1, m0 write addr 96 data 7 → same cycle m0_gnt=1, mem_en=1, mem_we=1, mem_addr=96, mem_wdata=7; next cycle m0_gnt=0 with req dropped.
- Both ports request writes in the same cycle after reset (m0: 100/25, m1: 104/9) → cycle 1 m0 granted (mem_addr=100, mem_wdata=25); cycle 2 m1 granted (mem_addr=104, mem_wdata=9).
- Both ports hold req for 4 writes each → grant sequence 0,1,0,1,0,1,0,1; no port waits more than 1 cycle.
- RD_LAT=2, m1 reads addr 96 at cycle T with memory returning 7 → m1_rvalid=1 and m1_rdata=7 at T+2; m0 write requested at T+1 gets gnt only at T+2; m0_rvalid stays 0 throughout.
- RD_LAT=1, m0 reads addr 96 then 100 on consecutive cycles (memory returns 7, 25) → m0_rvalid high for 2 consecutive cycles with rdata 7 then 25.
- RD_LAT=3, reset pulsed low at T+1 after an m0 read grant at T → no m0_rvalid ever for that read; all outputs 0 during reset; first grant after release goes to m0.
